// File: rtl/usb_tx_packet_fsm.sv
// USB TX packet controller: sequences SYNC, PID, payload, CRC16 and EOP around the bit timer,
// loading one byte into the serializer on each byte boundary and popping payload from the TX FIFO.
module usb_tx_packet_fsm #(
  parameter logic [7:0] SYNC_BYTE = 8'h80,
  parameter int         OCC_W     = 7
) (
  input  logic             clk,
  input  logic             n_rst,
  input  logic [2:0]       tx_packet,
  input  logic [7:0]       tx_packet_data,
  input  logic [OCC_W-1:0] buffer_occupancy,
  input  logic             byte_sent,
  input  logic             shift_enable,
  output logic             enable_timer,
  output logic [7:0]       tx_byte,
  output logic             load_byte,
  output logic             get_tx_packet_data,
  output logic             eop,
  output logic             tx_transfer_active,
  output logic             tx_error
);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] SYNC   = 3'd1;
  localparam logic [2:0] PID    = 3'd2;
  localparam logic [2:0] DATA   = 3'd3;
  localparam logic [2:0] CRC_LO = 3'd4;
  localparam logic [2:0] CRC_HI = 3'd5;
  localparam logic [2:0] EOP    = 3'd6;

  localparam logic [3:0] PID_DATA0 = 4'h3;
  localparam logic [3:0] PID_ACK   = 4'h2;
  localparam logic [3:0] PID_NAK   = 4'hA;
  localparam logic [3:0] PID_STALL = 4'hE;

  // Reflected CRC16 (poly 0xA001), one whole byte folded in LSB-first.
  function automatic logic [15:0] crc16_byte(input logic [15:0] crc_in, input logic [7:0] data);
    logic [15:0] c;
    c = crc_in;
    for (int i = 0; i < 8; i++) begin
      if ((c[0] ^ data[i]) == 1'b1) begin
        c = {1'b0, c[15:1]} ^ 16'hA001;
      end else begin
        c = {1'b0, c[15:1]};
      end
    end
    return c;
  endfunction

  logic [2:0]  state_r, state_s;
  logic [3:0]  pid_r, pid_s;
  logic [15:0] crc_r, crc_s;
  logic [1:0]  eop_cnt_r, eop_cnt_s;
  logic        byte_sent_q_r;
  logic        enable_timer_r, enable_timer_s;
  logic [7:0]  tx_byte_r, tx_byte_s;
  logic        load_byte_r, load_byte_s;
  logic        pop_r, pop_s;
  logic        eop_r, eop_s;
  logic        active_r;
  logic        tx_error_r, tx_error_s;
  logic        boundary_s;
  logic        occ_nz_s;

  assign boundary_s = byte_sent & ~byte_sent_q_r & enable_timer_r;
  assign occ_nz_s   = (buffer_occupancy != {OCC_W{1'b0}});

  // Next-state and next-output decode for the packet sequencer.
  always_comb begin
    state_s        = state_r;
    pid_s          = pid_r;
    crc_s          = crc_r;
    eop_cnt_s      = eop_cnt_r;
    enable_timer_s = enable_timer_r;
    tx_byte_s      = tx_byte_r;
    load_byte_s    = 1'b0;
    pop_s          = 1'b0;
    eop_s          = eop_r;
    tx_error_s     = 1'b0;
    case (state_r)
      IDLE: begin
        case (tx_packet)
          3'd1, 3'd2, 3'd3, 3'd4: begin
            case (tx_packet)
              3'd1:    pid_s = PID_DATA0;
              3'd2:    pid_s = PID_ACK;
              3'd3:    pid_s = PID_NAK;
              default: pid_s = PID_STALL;
            endcase
            state_s        = SYNC;
            tx_byte_s      = SYNC_BYTE;
            load_byte_s    = 1'b1;
            enable_timer_s = 1'b1;
            crc_s          = 16'hFFFF;
          end
          3'd5, 3'd6, 3'd7: tx_error_s = 1'b1;
          default:          state_s = IDLE;
        endcase
      end
      SYNC: begin
        if (boundary_s) begin
          state_s     = PID;
          tx_byte_s   = {~pid_r, pid_r};
          load_byte_s = 1'b1;
        end else begin
          state_s = SYNC;
        end
      end
      // PID and DATA share the "next payload byte or CRC" decision; handshakes go straight to EOP.
      PID, DATA: begin
        if (boundary_s) begin
          if ((state_r == PID) && (pid_r != PID_DATA0)) begin
            state_s   = EOP;
            eop_s     = 1'b1;
            eop_cnt_s = 2'd0;
          end else if (occ_nz_s) begin
            state_s     = DATA;
            tx_byte_s   = tx_packet_data;
            load_byte_s = 1'b1;
            pop_s       = 1'b1;
            crc_s       = crc16_byte(crc_r, tx_packet_data);
          end else begin
            state_s     = CRC_LO;
            tx_byte_s   = ~crc_r[7:0];
            load_byte_s = 1'b1;
          end
        end else begin
          state_s = state_r;
        end
      end
      CRC_LO: begin
        if (boundary_s) begin
          state_s     = CRC_HI;
          tx_byte_s   = ~crc_r[15:8];
          load_byte_s = 1'b1;
        end else begin
          state_s = CRC_LO;
        end
      end
      CRC_HI: begin
        if (boundary_s) begin
          state_s   = EOP;
          eop_s     = 1'b1;
          eop_cnt_s = 2'd0;
        end else begin
          state_s = CRC_HI;
        end
      end
      // Two SE0 bit-times, then one J bit-time before the timer is released.
      EOP: begin
        if (shift_enable) begin
          case (eop_cnt_r)
            2'd0: eop_cnt_s = 2'd1;
            2'd1: begin
              eop_cnt_s = 2'd2;
              eop_s     = 1'b0;
            end
            default: begin
              eop_cnt_s      = 2'd0;
              eop_s          = 1'b0;
              enable_timer_s = 1'b0;
              state_s        = IDLE;
            end
          endcase
        end else begin
          state_s = EOP;
        end
      end
      default: begin
        state_s        = IDLE;
        enable_timer_s = 1'b0;
        eop_s          = 1'b0;
        eop_cnt_s      = 2'd0;
      end
    endcase
  end

  // State and registered outputs.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_r        <= IDLE;
      pid_r          <= 4'h0;
      crc_r          <= 16'hFFFF;
      eop_cnt_r      <= 2'd0;
      byte_sent_q_r  <= 1'b0;
      enable_timer_r <= 1'b0;
      tx_byte_r      <= 8'h00;
      load_byte_r    <= 1'b0;
      pop_r          <= 1'b0;
      eop_r          <= 1'b0;
      active_r       <= 1'b0;
      tx_error_r     <= 1'b0;
    end else begin
      state_r        <= state_s;
      pid_r          <= pid_s;
      crc_r          <= crc_s;
      eop_cnt_r      <= eop_cnt_s;
      byte_sent_q_r  <= byte_sent;
      enable_timer_r <= enable_timer_s;
      tx_byte_r      <= tx_byte_s;
      load_byte_r    <= load_byte_s;
      pop_r          <= pop_s;
      eop_r          <= eop_s;
      active_r       <= (state_s != IDLE);
      tx_error_r     <= tx_error_s;
    end
  end

  assign enable_timer       = enable_timer_r;
  assign tx_byte            = tx_byte_r;
  assign load_byte          = load_byte_r;
  assign get_tx_packet_data = pop_r;
  assign eop                = eop_r;
  assign tx_transfer_active = active_r;
  assign tx_error           = tx_error_r;

endmodule

// File: tb/tb_usb_tx_packet_fsm.sv
// Bench for usb_tx_packet_fsm: emulates the bit timer and TX FIFO, checks byte stream, pops and EOP timing.
module tb_usb_tx_packet_fsm;

  logic       clk = 1'b0;
  logic       n_rst;
  logic [2:0] tx_packet;
  logic [7:0] tx_packet_data;
  logic [6:0] buffer_occupancy;
  logic       byte_sent;
  logic       shift_enable;
  logic       enable_timer;
  logic [7:0] tx_byte;
  logic       load_byte;
  logic       get_tx_packet_data;
  logic       eop;
  logic       tx_transfer_active;
  logic       tx_error;

  always #5 clk = ~clk;

  usb_tx_packet_fsm #(.SYNC_BYTE(8'h80), .OCC_W(7)) dut (
    .clk(clk), .n_rst(n_rst), .tx_packet(tx_packet), .tx_packet_data(tx_packet_data),
    .buffer_occupancy(buffer_occupancy), .byte_sent(byte_sent), .shift_enable(shift_enable),
    .enable_timer(enable_timer), .tx_byte(tx_byte), .load_byte(load_byte),
    .get_tx_packet_data(get_tx_packet_data), .eop(eop), .tx_transfer_active(tx_transfer_active),
    .tx_error(tx_error)
  );

  typedef struct {
    logic [2:0] code;
    int         len;
    logic [7:0] pl [0:8];
    int         hold;
    bit         chk_crc;
    logic [7:0] crc_lo;
    logic [7:0] crc_hi;
  } vec_t;

  int n_checks = 0;
  int n_fail   = 0;
  logic [7:0] payload_q [$];
  logic [7:0] fifo_q [$];
  logic [7:0] exp_q [$];
  logic [7:0] got_q [$];
  int pops, se_eop, se_j;
  vec_t vecs [0:6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Expected wire bytes: SYNC, PID with its complement, payload, then complemented CRC-16 over the payload.
  task automatic build_expected(input logic [2:0] code);
    logic [3:0]  pid;
    logic [15:0] crc;
    bit          fb;
    exp_q.delete();
    exp_q.push_back(8'h80);
    case (code)
      3'd1:    pid = 4'h3;
      3'd2:    pid = 4'h2;
      3'd3:    pid = 4'hA;
      default: pid = 4'hE;
    endcase
    exp_q.push_back({~pid, pid});
    if (code == 3'd1) begin
      crc = 16'hFFFF;
      foreach (payload_q[k]) begin
        exp_q.push_back(payload_q[k]);
        for (int b = 0; b < 8; b++) begin
          fb  = crc[0] ^ payload_q[k][b];
          crc = crc >> 1;
          if (fb) crc = crc ^ 16'hA001;
        end
      end
      exp_q.push_back(~crc[7:0]);
      exp_q.push_back(~crc[15:8]);
    end
  endtask

  task automatic drive_fifo();
    buffer_occupancy = 7'(fifo_q.size());
    tx_packet_data   = (fifo_q.size() != 0) ? fifo_q[0] : 8'h00;
  endtask

  // Request one packet and play the timer/FIFO until enable_timer drops (or abort after N pops).
  task automatic run_packet(input logic [2:0] code, input int hold_fix, input int abort_pops);
    int  tcnt, hold, phase, cyc;
    bit  trun, started, seen_eop, done;
    fifo_q = payload_q;
    got_q.delete();
    pops = 0; se_eop = 0; se_j = 0;
    tcnt = 0; hold = 0; phase = 0; trun = 0; started = 0; seen_eop = 0; done = 0;
    @(posedge clk); #1;
    tx_packet = code;
    drive_fifo();
    @(posedge clk); #1;
    tx_packet = 3'd0;
    for (cyc = 0; cyc < 3000; cyc++) begin
      if (load_byte) begin
        got_q.push_back(tx_byte);
        tcnt = $urandom_range(10, 4);
        trun = 1;
        started = 1;
      end
      if (get_tx_packet_data) begin
        pops++;
        if (fifo_q.size() != 0) void'(fifo_q.pop_front());
      end
      if (eop) seen_eop = 1;
      if (abort_pops > 0 && pops == abort_pops) begin
        n_rst = 1'b0;
        #1;
        check("rst_outputs", {enable_timer, tx_byte, load_byte, get_tx_packet_data, eop,
                              tx_transfer_active, tx_error}, 32'h0);
        repeat (3) @(posedge clk);
        #1;
        check("rst_hold_idle", {enable_timer, get_tx_packet_data, tx_transfer_active}, 32'h0);
        byte_sent = 1'b0; shift_enable = 1'b0;
        n_rst = 1'b1;
        done = 1;
        break;
      end
      if (started && !enable_timer) begin
        done = 1;
        break;
      end
      phase++;
      shift_enable = (phase % 3 == 0);
      if (shift_enable && enable_timer) begin
        if (eop) se_eop++;
        else if (seen_eop) se_j++;
      end
      if (hold > 0) begin
        byte_sent = 1'b1;
        hold--;
      end else begin
        byte_sent = 1'b0;
        if (trun) begin
          if (tcnt == 0) begin
            hold = (hold_fix > 0) ? hold_fix : $urandom_range(5, 1);
            trun = 0;
            byte_sent = 1'b1;
            hold--;
          end else begin
            tcnt--;
          end
        end
      end
      drive_fifo();
      @(posedge clk); #1;
    end
    check("packet_timeout", {31'h0, done}, 32'h1);
    byte_sent = 1'b0;
    shift_enable = 1'b0;
  endtask

  task automatic compare_packet(input string tag, input logic [2:0] code);
    build_expected(code);
    check({tag, "_nbytes"}, got_q.size(), exp_q.size());
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
      check($sformatf("%s_byte%0d", tag, i), got_q[i], exp_q[i]);
    check({tag, "_pops"}, pops, (code == 3'd1) ? payload_q.size() : 0);
    check({tag, "_eop_bits"}, se_eop, 2);
    check({tag, "_j_bits"}, se_j, 1);
    check({tag, "_active_end"}, {31'h0, tx_transfer_active}, 32'h0);
  endtask

  initial begin
    n_rst = 1'b0; tx_packet = 3'd0; tx_packet_data = 8'h00; buffer_occupancy = 7'd0;
    byte_sent = 1'b0; shift_enable = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_outputs", {enable_timer, tx_byte, load_byte, get_tx_packet_data, eop,
                            tx_transfer_active, tx_error}, 32'h0);
    n_rst = 1'b1;

    vecs[0] = '{code: 3'd2, len: 0, pl: '{default: 8'h00}, hold: 1, chk_crc: 0, crc_lo: 8'h00, crc_hi: 8'h00};
    vecs[1] = '{code: 3'd3, len: 0, pl: '{default: 8'h00}, hold: 5, chk_crc: 0, crc_lo: 8'h00, crc_hi: 8'h00};
    vecs[2] = '{code: 3'd4, len: 0, pl: '{default: 8'h00}, hold: 3, chk_crc: 0, crc_lo: 8'h00, crc_hi: 8'h00};
    vecs[3] = '{code: 3'd1, len: 0, pl: '{default: 8'h00}, hold: 5, chk_crc: 1, crc_lo: 8'h00, crc_hi: 8'h00};
    vecs[4] = '{code: 3'd1, len: 3, pl: '{8'h01, 8'h02, 8'h03, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00},
                hold: 5, chk_crc: 0, crc_lo: 8'h00, crc_hi: 8'h00};
    vecs[5] = '{code: 3'd1, len: 9, pl: '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39},
                hold: 2, chk_crc: 1, crc_lo: 8'hC8, crc_hi: 8'hB4};
    vecs[6] = '{code: 3'd1, len: 1, pl: '{8'hFF, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00},
                hold: 1, chk_crc: 0, crc_lo: 8'h00, crc_hi: 8'h00};

    for (int v = 0; v < 7; v++) begin
      payload_q.delete();
      for (int i = 0; i < vecs[v].len; i++) payload_q.push_back(vecs[v].pl[i]);
      run_packet(vecs[v].code, vecs[v].hold, 0);
      compare_packet($sformatf("vec%0d", v), vecs[v].code);
      if (vecs[v].chk_crc && got_q.size() >= 2) begin
        check($sformatf("vec%0d_crc_lo_const", v), got_q[got_q.size()-2], vecs[v].crc_lo);
        check($sformatf("vec%0d_crc_hi_const", v), got_q[got_q.size()-1], vecs[v].crc_hi);
      end
    end

    // Illegal request codes pulse tx_error for one clock and never start a transfer.
    for (int c = 5; c <= 7; c++) begin
      @(posedge clk); #1;
      tx_packet = 3'(c);
      @(posedge clk); #1;
      tx_packet = 3'd0;
      check($sformatf("err%0d_pulse", c), {31'h0, tx_error}, 32'h1);
      check($sformatf("err%0d_active", c), {31'h0, tx_transfer_active}, 32'h0);
      @(posedge clk); #1;
      check($sformatf("err%0d_pulse_end", c), {tx_error, tx_transfer_active, load_byte}, 32'h0);
    end

    // byte_sent activity while the timer is off must not load anything.
    byte_sent = 1'b1;
    repeat (3) begin
      @(posedge clk); #1;
      check("idle_byte_sent", {load_byte, tx_transfer_active, enable_timer}, 32'h0);
    end
    byte_sent = 1'b0;

    // Reset in the middle of a DATA0 payload, then a clean ACK.
    payload_q.delete();
    for (int i = 0; i < 5; i++) payload_q.push_back(8'(8'hA0 + i));
    run_packet(3'd1, 2, 2);
    check("rst_pops", pops, 2);
    payload_q.delete();
    run_packet(3'd2, 4, 0);
    compare_packet("post_rst_ack", 3'd2);

    // Randomized packets against the reference model.
    for (int r = 0; r < 30; r++) begin
      logic [2:0] code;
      int len;
      code = ($urandom_range(1, 0) == 1) ? 3'd1 : 3'($urandom_range(4, 2));
      len  = $urandom_range(8, 0);
      payload_q.delete();
      for (int i = 0; i < len; i++) payload_q.push_back(8'($urandom));
      run_packet(code, 0, 0);
      compare_packet($sformatf("rnd%0d", r), code);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
